pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_if.sv | 53 +++++
 rtl/pipeline_ctrl_lu.sv | 19 +
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline register sequencer.
// Holds the controller state encoding and the register-index width.
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED
    } pipe_ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and register enable/flush outputs of pipeline_ctrl.
// master: pipeline side driving events; slave: the controller.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dmemREN_EX_MEM;
    logic             dmemWEN_EX_MEM;
    logic             MemRead_ID_EX;
    logic [REG_W-1:0] Rt_ID_EX;
    logic [REG_W-1:0] Rs_IF_ID;
    logic [REG_W-1:0] Rt_IF_ID;
    logic             redirect_EX_MEM;
    logic             halt_EX_MEM;
    logic             halt;

    logic             pc_enable;
    logic             enable_IF_ID;
    logic             enable_ID_EX;
    logic             enable_EX_MEM;
    logic             enable_MEM_WB;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             flush_EX_MEM;
    logic             flush_MEM_WB;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic             dwait_timeout;

    modport master (
        output ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM,
        output MemRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
        output redirect_EX_MEM, halt_EX_MEM, halt,
        input  pc_enable,
        input  enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
        input  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
        input  halted, stall_count, dwait_timeout
    );

    modport slave (
        input  ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM,
        input  MemRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID,
        input  redirect_EX_MEM, halt_EX_MEM, halt,
        output pc_enable,
        output enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
        output flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
        output halted, stall_count, dwait_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_lu.sv
// Load-use hazard detect: EX-stage load whose destination is read in ID.
// Ports: MemRead_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID in; lu_hazard out.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic             MemRead_ID_EX,
    input  logic [REG_W-1:0] Rt_ID_EX,
    input  logic [REG_W-1:0] Rs_IF_ID,
    input  logic [REG_W-1:0] Rt_IF_ID,
    output logic             lu_hazard
);

    // $zero is never a real dependency
    assign lu_hazard = MemRead_ID_EX
                    && (Rt_ID_EX != '0)
                    && ((Rt_ID_EX == Rs_IF_ID)
                     || (Rt_ID_EX == Rt_IF_ID));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register sequencer: enables/flushes, PC enable, halt, debug counters.
// Ports: CLK, RST (sync, active high), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DWAIT_MAX = 256,
    parameter int CNT_W     = 32
) (
    input logic            CLK,
    input logic            RST,
    pipeline_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(DWAIT_MAX + 1);

    pipe_ctrl_state_t r_state;
    pipe_ctrl_state_t w_next;
    logic [WC_W-1:0]  r_wcnt;
    logic [CNT_W-1:0] r_stall;
    logic             r_tmo;

    logic       w_lu;
    logic       w_dwait;
    logic       w_pc;
    logic [3:0] w_en;
    logic [3:0] w_fl;

    load_use_detect u_lu (
        .MemRead_ID_EX (bus.MemRead_ID_EX),
        .Rt_ID_EX      (bus.Rt_ID_EX),
        .Rs_IF_ID      (bus.Rs_IF_ID),
        .Rt_IF_ID      (bus.Rt_IF_ID),
        .lu_hazard     (w_lu)
    );

    assign w_dwait = (bus.dmemREN_EX_MEM | bus.dmemWEN_EX_MEM)
                   & ~bus.dhit
                   & ((r_state == RUN) | (r_state == MEM_WAIT));

    always_ff @(posedge CLK) begin
        if (RST) r_state <= RUN;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN, MEM_WAIT: begin
                if (w_dwait)              w_next = MEM_WAIT;
                else if (bus.halt_EX_MEM) w_next = DRAIN;
                else                      w_next = RUN;
            end
            DRAIN:   if (bus.halt) w_next = HALTED;
            HALTED:  w_next = HALTED;
            default: w_next = RUN;
        endcase
    end

    // en/fl bit order: {IF_ID, ID_EX, EX_MEM, MEM_WB}
    always_comb begin
        w_pc = 1'b0;
        w_en = 4'b0000;
        w_fl = 4'b0000;
        if (RST) begin
            w_fl = 4'b1111;
        end else begin
            unique case (r_state)
                RUN, MEM_WAIT: begin
                    priority case (1'b1)
                        w_dwait: begin
                            w_en = 4'b0001;
                            w_fl = 4'b0001;
                        end
                        // halt outranks redirect: no target load
                        bus.halt_EX_MEM: begin
                            w_en = 4'b1111;
                            w_fl = 4'b1110;
                        end
                        bus.redirect_EX_MEM: begin
                            w_pc = 1'b1;
                            w_en = 4'b1111;
                            w_fl = 4'b1110;
                        end
                        w_lu: begin
                            w_en = 4'b0111;
                            w_fl = 4'b0100;
                        end
                        ~bus.ihit: begin
                            w_en = 4'b1111;
                            w_fl = 4'b1000;
                        end
                        default: begin
                            w_pc = bus.ihit;
                            w_en = 4'b1111;
                        end
                    endcase
                end
                DRAIN:   w_en = 4'b0001;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wcnt  <= '0;
            r_stall <= '0;
            r_tmo   <= 1'b0;
        end else begin
            if (w_dwait) begin
                if (r_wcnt != WC_W'(DWAIT_MAX))
                    r_wcnt <= r_wcnt + WC_W'(1);
                // this wait cycle brings the count to DWAIT_MAX
                if (r_wcnt >= WC_W'(DWAIT_MAX - 1))
                    r_tmo <= 1'b1;
            end else begin
                r_wcnt <= '0;
            end
            if (!w_pc && (r_state != HALTED) && !(&r_stall))
                r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign bus.pc_enable     = w_pc;
    assign bus.enable_IF_ID  = w_en[3];
    assign bus.enable_ID_EX  = w_en[2];
    assign bus.enable_EX_MEM = w_en[1];
    assign bus.enable_MEM_WB = w_en[0];
    assign bus.flush_IF_ID   = w_fl[3];
    assign bus.flush_ID_EX   = w_fl[2];
    assign bus.flush_EX_MEM  = w_fl[1];
    assign bus.flush_MEM_WB  = w_fl[0];
    assign bus.halted        = ~RST & (r_state == HALTED);
    assign bus.stall_count   = r_stall;
    assign bus.dwait_timeout = r_tmo;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic,
// all checked against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int DW = 4;
    localparam int CW = 8;
    localparam int SMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pipeline_ctrl_if #(.CNT_W(CW)) bus();

    pipeline_ctrl #(.DWAIT_MAX(DW), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;

    // model: pipeline mode, consecutive dmem-wait cycles, counters
    bit m_halted, m_drain, m_tmo;
    int m_wait, m_stall;

    function automatic logic [8:0] act_out();
        return {bus.pc_enable,
                bus.enable_IF_ID, bus.enable_ID_EX,
                bus.enable_EX_MEM, bus.enable_MEM_WB,
                bus.flush_IF_ID, bus.flush_ID_EX,
                bus.flush_EX_MEM, bus.flush_MEM_WB};
    endfunction

    function automatic bit m_dwait();
        return (bus.dmemREN_EX_MEM || bus.dmemWEN_EX_MEM) && !bus.dhit;
    endfunction

    // {pc, en IF_ID..MEM_WB, flush IF_ID..MEM_WB}
    function automatic logic [8:0] model_out();
        logic [4:0] ld;
        bit lu;
        ld = bus.Rt_ID_EX;
        lu = bus.MemRead_ID_EX && ld != 0
          && (ld == bus.Rs_IF_ID || ld == bus.Rt_IF_ID);
        if (RST)                 return 9'b0_0000_1111;
        if (m_halted)            return 9'b0_0000_0000;
        if (m_drain)             return 9'b0_0001_0000;
        if (m_dwait())           return 9'b0_0001_0001;
        if (bus.halt_EX_MEM)     return 9'b0_1111_1110;
        if (bus.redirect_EX_MEM) return 9'b1_1111_1110;
        if (lu)                  return 9'b0_0111_0100;
        if (!bus.ihit)           return 9'b0_1111_1000;
        return 9'b1_1111_0000;
    endfunction

    always @(posedge CLK) begin
        logic [8:0] e;
        if (RST) begin
            m_halted = 0; m_drain = 0; m_tmo = 0;
            m_wait = 0; m_stall = 0;
        end else begin
            e = model_out();
            if (!m_halted && !e[8] && m_stall < SMAX)
                m_stall = m_stall + 1;
            if (m_halted) begin
            end else if (m_drain) begin
                if (bus.halt) begin
                    m_halted = 1;
                    m_drain  = 0;
                end
            end else if (m_dwait()) begin
                m_wait = m_wait + 1;
                if (m_wait >= DW) m_tmo = 1;
            end else begin
                m_wait = 0;
                if (bus.halt_EX_MEM) m_drain = 1;
            end
        end
        chk_en <= 1'b1;
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("outs", int'(act_out()), int'(model_out()));
            check("halted", int'(bus.halted), int'(!RST && m_halted));
            check("stall", int'(bus.stall_count), m_stall);
            check("tmo", int'(bus.dwait_timeout), int'(m_tmo));
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.ihit = 1; bus.dhit = 0;
        bus.dmemREN_EX_MEM = 0; bus.dmemWEN_EX_MEM = 0;
        bus.MemRead_ID_EX = 0;
        bus.Rt_ID_EX = 0; bus.Rs_IF_ID = 0; bus.Rt_IF_ID = 0;
        bus.redirect_EX_MEM = 0; bus.halt_EX_MEM = 0; bus.halt = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        cyc();
        RST = 0;
    endtask

    initial begin
        idle();
        RST = 1;
        cyc();
        cyc();
        @(negedge CLK);
        check("rst_outs", int'(act_out()), 'h00F);
        check("rst_stall", int'(bus.stall_count), 0);
        cyc();
        RST = 0;
        cyc();
        @(negedge CLK);
        check("run_stall0", int'(bus.stall_count), 0);
        check("run_outs", int'(act_out()), 'h1F0);

        cyc();
        bus.dmemREN_EX_MEM = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("dwait_outs", int'(act_out()), 'h011);
            check("dwait_tmo", int'(bus.dwait_timeout), (i >= 4) ? 1 : 0);
            cyc();
        end
        bus.dhit = 1;
        @(negedge CLK);
        check("dhit_adv", int'(act_out()), 'h1F0);
        cyc();
        bus.dmemREN_EX_MEM = 0;
        bus.dhit = 0;
        @(negedge CLK);
        check("dwait_stall5", int'(bus.stall_count), 5);
        check("tmo_sticky", int'(bus.dwait_timeout), 1);

        cyc();
        do_reset();
        bus.MemRead_ID_EX = 1; bus.Rt_ID_EX = 8; bus.Rs_IF_ID = 8;
        @(negedge CLK);
        check("lu_bubble", int'(act_out()), 'h074);
        check("tmo_cleared", int'(bus.dwait_timeout), 0);
        cyc();
        bus.MemRead_ID_EX = 0;
        @(negedge CLK);
        check("lu_once", int'(act_out()), 'h1F0);
        check("lu_stall1", int'(bus.stall_count), 1);
        cyc();
        bus.MemRead_ID_EX = 1; bus.Rt_ID_EX = 0; bus.Rs_IF_ID = 0;
        @(negedge CLK);
        check("lu_zero", int'(act_out()), 'h1F0);
        cyc();
        bus.Rt_ID_EX = 8; bus.Rt_IF_ID = 8; bus.Rs_IF_ID = 3;
        bus.redirect_EX_MEM = 1;
        @(negedge CLK);
        check("redir_lu", int'(act_out()), 'h1FE);

        cyc();
        bus.MemRead_ID_EX = 0;
        bus.dmemWEN_EX_MEM = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("redir_wait", int'(act_out()), 'h011);
            cyc();
        end
        bus.dhit = 1;
        @(negedge CLK);
        check("redir_dhit", int'(act_out()), 'h1FE);

        cyc();
        idle();
        bus.halt_EX_MEM = 1; bus.redirect_EX_MEM = 1;
        @(negedge CLK);
        check("halt_wins", int'(act_out()), 'h0FE);
        cyc();
        idle();
        bus.halt = 1;
        @(negedge CLK);
        check("drain_outs", int'(act_out()), 'h010);
        check("drain_nhalt", int'(bus.halted), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.ihit = i[0];
            bus.dhit = ~i[0];
            bus.dmemREN_EX_MEM = 1;
            @(negedge CLK);
            check("halted", int'(bus.halted), 1);
            check("halted_outs", int'(act_out()), 0);
        end
        cyc();
        idle();
        RST = 1;
        @(negedge CLK);
        check("rst_unhalt", int'(bus.halted), 0);
        cyc();
        RST = 0;

        bus.dmemREN_EX_MEM = 1;
        repeat (300) cyc();
        @(negedge CLK);
        check("stall_sat", int'(bus.stall_count), SMAX);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            RST = ($urandom_range(0, 99) == 0);
            bus.ihit = ($urandom_range(0, 3) != 0);
            bus.dhit = $urandom_range(0, 1);
            bus.dmemREN_EX_MEM = ($urandom_range(0, 3) == 0);
            bus.dmemWEN_EX_MEM = ($urandom_range(0, 5) == 0);
            bus.MemRead_ID_EX = $urandom_range(0, 1);
            bus.Rt_ID_EX = 5'($urandom_range(0, 3));
            bus.Rs_IF_ID = 5'($urandom_range(0, 3));
            bus.Rt_IF_ID = 5'($urandom_range(0, 3));
            bus.redirect_EX_MEM = ($urandom_range(0, 7) == 0);
            bus.halt_EX_MEM = ($urandom_range(0, 49) == 0);
            bus.halt = ($urandom_range(0, 2) == 0);
        end
        cyc();
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
